// File: rtl/vector_mem_responder.sv
// ============================================================================
// Module      : vector_mem_responder
// Description : Completer for vector loads/stores. Owns a byte-addressed SRAM
//               and serves whole-line or single-element accesses with a
//               fixed, programmable read latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vector_mem_responder #(
   parameter int DATA_WIDTH    = 256,
   parameter int MEM_BYTES     = 32768,
   parameter int READ_LATENCY  = 2,
   parameter int WRITE_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mem_valid_rd,
   input  logic                  mem_valid_wr,
   input  logic                  mem_unit,
   input  logic [1:0]            mem_sew,
   input  logic [31:0]           mem_address,
   input  logic [DATA_WIDTH-1:0] mem_data_wr,
   output logic                  mem_ready,
   output logic                  mem_valid_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,
   output logic                  protocol_err
);

   localparam int ADDR_W  = $clog2(MEM_BYTES);
   localparam int LINE_W  = ADDR_W - 5;
   localparam int LINES   = MEM_BYTES / 32;
   localparam int CNT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = (WRITE_LATENCY > 0) ? CNT_W'(WRITE_LATENCY - 1) : '0;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RD_WAIT = 2'd1,
      WR_WAIT = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   data_o_q, data_o_d;
   logic [DATA_WIDTH-1:0]   rsp_q, rsp_d;
   logic                    err_q, err_d;

   logic [DATA_WIDTH-1:0]   mem_array [LINES];

   logic                    accept;
   logic                    is_write;
   logic [ADDR_W-1:0]       ea;
   logic [LINE_W-1:0]       line_idx;
   logic [4:0]              elem_off;
   logic [7:0]              elem_shift;
   logic [31:0]             elem_be_base;
   logic [31:0]             byte_en;
   logic [DATA_WIDTH-1:0]   elem_mask;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [DATA_WIDTH-1:0]   rd_line;
   logic [DATA_WIDTH-1:0]   rd_snapshot;
   logic                    unused_addr_hi;

   // Address bits above the array size are deliberately ignored (wrap-around).
   assign unused_addr_hi = ^mem_address[31:ADDR_W];

   assign accept   = ready_q & (mem_valid_rd | mem_valid_wr);
   assign is_write = mem_valid_wr;

   always_comb begin
      ea         = mem_address[ADDR_W-1:0];
      line_idx   = ea[ADDR_W-1:5];
      elem_off   = ea[4:0] & (5'b11111 << mem_sew);
      elem_shift = {elem_off, 3'b000};
      case (mem_sew)
         2'b00:   begin elem_be_base = 32'h0000_0001; elem_mask = DATA_WIDTH'(64'h0000_0000_0000_00FF); end
         2'b01:   begin elem_be_base = 32'h0000_0003; elem_mask = DATA_WIDTH'(64'h0000_0000_0000_FFFF); end
         2'b10:   begin elem_be_base = 32'h0000_000F; elem_mask = DATA_WIDTH'(64'h0000_0000_FFFF_FFFF); end
         default: begin elem_be_base = 32'h0000_00FF; elem_mask = DATA_WIDTH'(64'hFFFF_FFFF_FFFF_FFFF); end
      endcase
      byte_en     = mem_unit ? 32'hFFFF_FFFF : (elem_be_base << elem_off);
      wr_data     = mem_unit ? mem_data_wr : (mem_data_wr << elem_shift);
      rd_line     = mem_array[line_idx];
      rd_snapshot = mem_unit ? rd_line : ((rd_line >> elem_shift) & elem_mask);
   end

   // Writes commit at the accept edge so a following read sees them.
   always_ff @(posedge clk) begin
      if (accept && is_write) begin
         for (int b = 0; b < 32; b++) begin
            if (byte_en[b]) begin
               mem_array[line_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ready_d  = ready_q;
      valid_d  = 1'b0;
      data_o_d = data_o_q;
      rsp_d    = rsp_q;
      err_d    = err_q;
      if (accept) begin
         if (is_write) begin
            err_d = err_q | mem_valid_rd;
            if (WRITE_LATENCY == 0) begin
               state_d = IDLE;
               ready_d = 1'b1;
            end else begin
               state_d = WR_WAIT;
               cnt_d   = WR_LOAD;
               ready_d = 1'b0;
            end
         end else begin
            rsp_d   = rd_snapshot;
            state_d = RD_WAIT;
            cnt_d   = RD_LOAD;
            if (READ_LATENCY == 1) begin
               valid_d  = 1'b1;
               data_o_d = rd_snapshot;
               ready_d  = 1'b1;
            end else begin
               ready_d  = 1'b0;
            end
         end
      end else begin
         case (state_q)
            RD_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
                  if (cnt_q == CNT_W'(1)) begin
                     valid_d  = 1'b1;
                     data_o_d = rsp_q;
                     ready_d  = 1'b1;
                  end
               end
            end
            WR_WAIT: begin
               if (cnt_q == '0) begin
                  state_d = IDLE;
                  ready_d = 1'b1;
               end else begin
                  cnt_d = cnt_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               ready_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         data_o_q <= '0;
         rsp_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         data_o_q <= data_o_d;
         rsp_q    <= rsp_d;
         err_q    <= err_d;
      end
   end

   assign mem_ready    = ready_q;
   assign mem_valid_o  = valid_q;
   assign mem_data_o   = data_o_q;
   assign protocol_err = err_q;

endmodule

`default_nettype wire

// File: tb/tb_vector_mem_responder.sv
// ============================================================================
// Module      : tb_vector_mem_responder
// Description : Directed self-checking bench for vector_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vector_mem_responder;

   localparam int RL = 2;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         mem_valid_rd, mem_valid_wr, mem_unit;
   logic [1:0]   mem_sew;
   logic [31:0]  mem_address;
   logic [255:0] mem_data_wr;
   logic         mem_ready, mem_valid_o, protocol_err;
   logic [255:0] mem_data_o;

   int n_vec = 0;
   int n_err = 0;

   logic [255:0] exp_line;
   logic [255:0] dead_line;
   logic [255:0] cafe_line;

   vector_mem_responder #(
      .DATA_WIDTH(256), .MEM_BYTES(32768), .READ_LATENCY(RL), .WRITE_LATENCY(1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_valid_rd(mem_valid_rd), .mem_valid_wr(mem_valid_wr),
      .mem_unit(mem_unit), .mem_sew(mem_sew), .mem_address(mem_address),
      .mem_data_wr(mem_data_wr), .mem_ready(mem_ready),
      .mem_valid_o(mem_valid_o), .mem_data_o(mem_data_o),
      .protocol_err(protocol_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Presents a request and returns at accept edge + 1.
   task automatic issue(input logic rd, input logic wr, input logic unit,
                        input logic [1:0] sew, input logic [31:0] addr,
                        input logic [255:0] data);
      int w = 0;
      mem_valid_rd = rd; mem_valid_wr = wr; mem_unit = unit;
      mem_sew = sew; mem_address = addr; mem_data_wr = data;
      while (mem_ready !== 1'b1 && w < 20) begin
         @(posedge clk); #1; w++;
      end
      if (w >= 20) check("ready_timeout", 256'(mem_ready), 256'(1));
      @(posedge clk); #1;
      mem_valid_rd = 1'b0; mem_valid_wr = 1'b0;
   endtask

   task automatic write_chk(input string tag, input logic unit, input logic [1:0] sew,
                            input logic [31:0] addr, input logic [255:0] data);
      issue(1'b0, 1'b1, unit, sew, addr, data);
      check({tag, "_rdy_low"}, 256'(mem_ready), 256'(0));
      check({tag, "_novalid"}, 256'(mem_valid_o), 256'(0));
      @(posedge clk); #1;
      check({tag, "_rdy_back"}, 256'(mem_ready), 256'(1));
   endtask

   task automatic read_chk(input string tag, input logic unit, input logic [1:0] sew,
                           input logic [31:0] addr, input logic [255:0] exp);
      int first = 0;
      int pulses = 0;
      logic [255:0] got = '0;
      issue(1'b1, 1'b0, unit, sew, addr, 256'h0);
      for (int k = 1; k <= 6; k++) begin
         if (k == 1) check({tag, "_rdy_t1"}, 256'(mem_ready), 256'(0));
         if (k == RL) check({tag, "_rdy_tv"}, 256'(mem_ready), 256'(1));
         if (mem_valid_o === 1'b1) begin
            pulses++;
            if (first == 0) begin
               first = k;
               got = mem_data_o;
            end
         end
         if (k < 6) begin @(posedge clk); #1; end
      end
      check({tag, "_lat"}, 256'(first), 256'(RL));
      check({tag, "_pulses"}, 256'(pulses), 256'(1));
      check({tag, "_data"}, got, exp);
      check({tag, "_hold"}, mem_data_o, exp);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      rst_n = 1'b0;
      mem_valid_rd = 1'b0; mem_valid_wr = 1'b0; mem_unit = 1'b0;
      mem_sew = 2'b00; mem_address = '0; mem_data_wr = '0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      check("rst_ready", 256'(mem_ready), 256'(1));
      check("rst_valid", 256'(mem_valid_o), 256'(0));
      check("rst_data", mem_data_o, 256'h0);
      check("rst_perr", 256'(protocol_err), 256'(0));

      for (int i = 0; i < 32; i++) exp_line[i*8 +: 8] = 8'(i);
      write_chk("t2_wr", 1'b1, 2'b00, 32'h40, exp_line);
      read_chk("t2_rd", 1'b1, 2'b00, 32'h40, exp_line);

      // Upper junk in write data must not reach the array.
      write_chk("t3_wr", 1'b0, 2'b00, 32'h41, {{31{8'hEE}}, 8'hAB});
      exp_line[15:8] = 8'hAB;
      read_chk("t3_rd", 1'b1, 2'b00, 32'h5F, exp_line);

      write_chk("t4_wr", 1'b0, 2'b11, 32'h47, {{24{8'h99}}, 64'h1122334455667788});
      exp_line[63:0] = 64'h1122334455667788;
      read_chk("t4_rd32", 1'b0, 2'b10, 32'h44, 256'h11223344);
      read_chk("t4_rd16", 1'b0, 2'b01, 32'h43, 256'h5566);
      read_chk("t4_rd8", 1'b0, 2'b00, 32'h45, 256'h33);
      read_chk("t4_line", 1'b1, 2'b00, 32'h40, exp_line);

      dead_line = {8{32'hDEADBEEF}};
      write_chk("t5_wr", 1'b1, 2'b00, 32'h8000, dead_line);
      read_chk("t5_rd0", 1'b1, 2'b00, 32'h0, dead_line);
      read_chk("t5_wrap", 1'b1, 2'b00, 32'hFFFF_8040, exp_line);

      cafe_line = {8{32'hCAFEF00D}};
      issue(1'b1, 1'b1, 1'b1, 2'b00, 32'h20, cafe_line);
      check("t5_perr_set", 256'(protocol_err), 256'(1));
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         if (mem_valid_o === 1'b1) pulses++;
         @(posedge clk); #1;
      end
      check("t5_both_novalid", 256'(pulses), 256'(0));
      read_chk("t5_both_rd", 1'b1, 2'b00, 32'h20, cafe_line);
      check("t5_perr_sticky", 256'(protocol_err), 256'(1));

      issue(1'b1, 1'b0, 1'b1, 2'b00, 32'h40, 256'h0);
      rst_n = 1'b0;
      #3;
      check("t6_rst_ready", 256'(mem_ready), 256'(1));
      check("t6_rst_perr", 256'(protocol_err), 256'(0));
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk); #1;
         if (mem_valid_o === 1'b1) pulses++;
      end
      check("t6_novalid", 256'(pulses), 256'(0));
      check("t6_ready", 256'(mem_ready), 256'(1));
      check("t6_data", mem_data_o, 256'h0);
      read_chk("t6_keep0", 1'b1, 2'b00, 32'h0, dead_line);
      read_chk("t6_keep40", 1'b1, 2'b00, 32'h40, exp_line);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
